// File: rtl/accumulator_rr_arbiter_if.sv
// Stream bundle between NUM_SRC requesters, the round-robin arbiter and the accumulator input.
// The master modport is the arbiter's view. The slave modport is the view of the requesters and the accumulator.
interface accumulator_rr_arbiter_if #(
   parameter int WIDTH   = 3,
   parameter int NUM_SRC = 3,
   parameter int ID_W    = $clog2(NUM_SRC)
);
   logic [NUM_SRC-1:0]            s_valid;
   logic [NUM_SRC-1:0]            s_ready;
   logic [NUM_SRC-1:0][WIDTH-1:0] s_data;
   logic                          m_valid;
   logic                          m_ready;
   logic [WIDTH-1:0]              m_data;
   logic [ID_W-1:0]               m_id;
   logic                          m_last;
   logic                          busy;

   modport master (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_id, m_last, busy
   );

   modport slave (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_id, m_last, busy
   );
endinterface

// File: rtl/accumulator_rr_arbiter.sv
// Round-robin arbiter that grants one requester for a whole accumulation burst of NO_OF_STEPS beats.
// Data passes through combinationally while a grant is held. A grant ends only after its last beat is accepted.
module accumulator_rr_arbiter #(
   parameter int WIDTH       = 3,
   parameter int NO_OF_STEPS = 4,
   parameter int NUM_SRC     = 3,
   parameter int ID_W        = $clog2(NUM_SRC)
) (
   input  logic                     clk,
   input  logic                     rstn,
   accumulator_rr_arbiter_if.master bus
);
   localparam int              CNT_W    = $clog2(NO_OF_STEPS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NO_OF_STEPS - 1);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_SRC - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t           state;
   logic [ID_W-1:0]  grant;
   logic [ID_W-1:0]  rr_ptr;
   logic [CNT_W-1:0] beat_cnt;

   logic             req_any;
   logic [ID_W-1:0]  winner;
   logic             in_burst;
   logic             accept;

   // Search for the first requester, starting at rr_ptr and wrapping explicitly, because NUM_SRC need not be a power of 2.
   always_comb begin
      logic [ID_W-1:0] idx;
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      req_any = 1'b0;
      winner  = rr_ptr;
      idx     = rr_ptr;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!req_any && bus.s_valid[idx]) begin
            req_any = 1'b1;
            winner  = idx;
         end
         idx = (idx == LAST_ID) ? '0 : idx + ID_W'(1);
      end
   end

   always_comb begin
      in_burst     = (state == BURST);
      bus.m_valid  = in_burst && bus.s_valid[grant];
      bus.m_data   = bus.m_valid ? bus.s_data[grant] : '0;
      bus.s_ready  = '0;
      if (in_burst) bus.s_ready[grant] = bus.m_ready;
      bus.m_last   = bus.m_valid && (beat_cnt == LAST_CNT);
      bus.m_id     = grant;
      bus.busy     = in_burst;
      accept       = bus.m_valid && bus.m_ready;
   end

   // NOTE: state registers use non-blocking assignments so that every flop samples values from before the clock edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  grant    <= winner;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               // There is no preemption: a stalled grant keeps its place until its final beat is accepted.
               if (accept) begin
                  if (beat_cnt == LAST_CNT) begin
                     beat_cnt <= '0;
                     rr_ptr   <= (grant == LAST_ID) ? '0 : grant + ID_W'(1);
                     state    <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
